sipo_deserializer: RTL and testbench
====================================

// Module: sipo_deserializer
// PURPOSE
//   Serial-in parallel-out receiver: the other end of the 4-bit PISO link. Collects
//   WIDTH bits, LSB first, into a word. Presents the word on a holding register with
//   a valid/ack handshake. Sits at the receive side of the serial datapath.
// PARAMETERS
//   WIDTH  4  word length in bits (>=2); also the bit-counter terminal count
// PORTS
//   CLK           in   1      rising-edge clock, sole clock domain
//   RST_N         in   1      asynchronous active-low reset
//   Serial_IN     in   1      serial data bit, sampled when Shift_EN=1
//   Shift_EN      in   1      bit strobe: 1 = consume Serial_IN this cycle
//   Clear         in   1      synchronous abort: drop partial word, clear flags
//   Out_Ack       in   1      consumer accepts Parallel_OUT (valid only with Out_Valid)
//   Parallel_OUT  out  WIDTH  last completed word (registered)
//   Out_Valid     out  1      1 = Parallel_OUT holds an unacknowledged word
//   Overrun       out  1      sticky: a word completed while previous was unacked
//   Bit_Count     out  clog2(WIDTH)  bits collected in current partial word
// BEHAVIOUR
//   Reset (RST_N=0, async): shift reg, Bit_Count, Parallel_OUT=0; Out_Valid=0; Overrun=0.
//   Shift path, per CLK with Shift_EN=1 and Clear=0:
//     sr <= {Serial_IN, sr[WIDTH-1:1]}  (first bit received ends at bit 0)
//     Bit_Count <= Bit_Count+1; at WIDTH-1 it wraps to 0 and the word completes.
//   Shift_EN=0: sr and Bit_Count hold; gaps of any length allowed between bits.
//   Word complete (Shift_EN=1, Bit_Count=WIDTH-1): same edge loads
//     Parallel_OUT <= {Serial_IN, sr[WIDTH-1:1]}; Out_Valid=1 from next cycle.
//     Latency: Out_Valid rises 1 cycle after the edge that samples the last bit.
//   Output FSM (Out_Valid is the state bit):
//     EMPTY (0): completion -> FULL.
//     FULL  (1): Out_Ack=1 and no completion -> EMPTY.
//                Out_Ack=1 and completion same edge -> FULL with new word, no Overrun.
//                Out_Ack=0 and completion -> FULL, new word overwrites, Overrun<=1.
//   Out_Ack while EMPTY: ignored.
//   Overrun: sticky; cleared only by Clear or reset.
//   Parallel_OUT stable while Out_Valid=1 unless an overrun overwrite occurs.
//   Clear=1 (sync, priority over Shift_EN and Out_Ack): sr=0, Bit_Count=0,
//     Out_Valid=0, Overrun=0; Parallel_OUT holds its last value.
//   Reset asserted mid-word: partial word discarded, everything to reset values;
//     first Shift_EN after release is bit 0 of a new word.
// TESTING (WIDTH=4)
//   1. Shift 1,0,1,1 on 4 consecutive cycles -> Parallel_OUT=4'b1101,
//      Out_Valid=1 the cycle after the 4th bit, Bit_Count=0.
//   2. Same bits with 3-cycle Shift_EN gaps -> identical word. Bit_Count steps 1,2,3,0.
//      Out_Valid stays 0 until 4th bit.
//   3. Word A=4'hA unacked, then word 4'h5 completes -> Parallel_OUT=4'h5,
//      Overrun=1 stays set. Clear -> Overrun=0, Out_Valid=0.
//   4. Out_Ack on exact edge word 4'h3 completes over unacked 4'hC ->
//      Parallel_OUT=4'h3, Out_Valid=1, Overrun=0.
//   5. 2 bits shifted, then RST_N pulsed low mid-cycle -> all outputs 0 immediately.
//      Next 4 bits 0,1,1,0 -> Parallel_OUT=4'b0110.
//   6. 3 bits shifted, Clear with Shift_EN=1 -> Bit_Count=0, bit dropped, no Out_Valid.

Source files
------------

// File: rtl/sipo_deserializer_if.sv
// Serial link receive bundle: bit strobe and controls in, completed word and status out.
// The master drives the serial side and acknowledges words; the slave is the deserializer.
interface sipo_deserializer_if #(
    parameter int WIDTH = 4
);
    localparam int CW = $clog2(WIDTH);

    logic             Serial_IN;
    logic             Shift_EN;
    logic             Clear;
    logic             Out_Ack;
    logic [WIDTH-1:0] Parallel_OUT;
    logic             Out_Valid;
    logic             Overrun;
    logic [CW-1:0]    Bit_Count;

    modport master (
        output Serial_IN, Shift_EN, Clear, Out_Ack,
        input  Parallel_OUT, Out_Valid, Overrun, Bit_Count
    );

    modport slave (
        input  Serial_IN, Shift_EN, Clear, Out_Ack,
        output Parallel_OUT, Out_Valid, Overrun, Bit_Count
    );
endinterface

// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out receiver: gathers WIDTH bits LSB first and hands the word
// to a consumer through a holding register with a valid/ack handshake and overrun flag.
//
// state | meaning
// EMPTY | holding register has no unacknowledged word (Out_Valid=0)
// FULL  | Parallel_OUT holds a word awaiting Out_Ack (Out_Valid=1)
module sipo_deserializer #(
    parameter int WIDTH = 4
) (
    input  logic               CLK,
    input  logic               RST_N,
    sipo_deserializer_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] next_word;
    logic [WIDTH-1:0] par_q;
    logic [CW-1:0]    bit_cnt;
    logic             overrun_q;
    logic             complete;

    assign next_word = {bus.Serial_IN, sr[WIDTH-1:1]};
    assign complete  = bus.Shift_EN && !bus.Clear && (bit_cnt == LAST_BIT);

    // Shift register and bit counter; Clear drops any partial word.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (bus.Clear) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (bus.Shift_EN) begin
            sr      <= next_word;
            bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
        end
    end

    // Holding register handshake; Parallel_OUT deliberately survives Clear.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= EMPTY;
            par_q     <= '0;
            overrun_q <= 1'b0;
        end else if (bus.Clear) begin
            state     <= EMPTY;
            overrun_q <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (complete) begin
                        par_q <= next_word;
                        state <= FULL;
                    end
                end
                FULL: begin
                    if (complete) begin
                        par_q <= next_word;
                        if (!bus.Out_Ack) begin
                            overrun_q <= 1'b1;
                        end
                    end else if (bus.Out_Ack) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign bus.Parallel_OUT = par_q;
    assign bus.Out_Valid    = (state == FULL);
    assign bus.Overrun      = overrun_q;
    assign bus.Bit_Count    = bit_cnt;
endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: directed link scenarios plus random traffic, each cycle's
// expected outputs come from a queue-of-bits reference model and are checked by a monitor.
module tb_sipo_deserializer;
    localparam int W  = 4;
    localparam int CW = $clog2(W);

    typedef struct packed {
        logic [W-1:0]  par;
        logic          valid;
        logic          ovr;
        logic [CW-1:0] cnt;
    } obs_t;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    sipo_deserializer_if #(.WIDTH(W)) bus ();
    sipo_deserializer #(.WIDTH(W)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));

    obs_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // reference model: bits received so far in the partial word, plus holding register
    int           m_bits[$];
    logic [W-1:0] m_par;
    logic         m_valid;
    logic         m_ovr;

    task automatic model_reset();
        m_bits.delete();
        m_par   = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic model_step(input logic sin, input logic sen, input logic clr, input logic ack);
        int v;
        if (clr) begin
            m_bits.delete();
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end else begin
            bit done = 1'b0;
            if (sen) begin
                m_bits.push_back(sin ? 1 : 0);
                if (m_bits.size() == W) begin
                    v = 0;
                    for (int i = 0; i < W; i++) v += m_bits[i] * (1 << i);
                    m_bits.delete();
                    done = 1'b1;
                end
            end
            if (done) begin
                if (m_valid && !ack) m_ovr = 1'b1;
                m_valid = 1'b1;
                m_par   = W'(v);
            end else if (m_valid && ack) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic sin, input logic sen, input logic clr, input logic ack);
        @(negedge CLK);
        bus.Serial_IN = sin;
        bus.Shift_EN  = sen;
        bus.Clear     = clr;
        bus.Out_Ack   = ack;
        model_step(sin, sen, clr, ack);
        exp_q.push_back('{m_par, m_valid, m_ovr, CW'(m_bits.size())});
    endtask

    task automatic idle();
        drive(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_word(input logic [W-1:0] w, input int gap, input logic ack_last);
        for (int i = 0; i < W; i++) begin
            drive(w[i], 1'b1, 1'b0, (i == W - 1) ? ack_last : 1'b0);
            if (i < W - 1) repeat (gap) idle();
        end
    endtask

    task automatic wait_edge();
        @(posedge CLK);
        #1;
    endtask

    // monitor: pops one expected observation per clock edge covered by stimulus
    initial begin : monitor
        obs_t e;
        obs_t a;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{bus.Parallel_OUT, bus.Out_Valid, bus.Overrun, bus.Bit_Count};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL cycle t=%0t got par=%h valid=%b ovr=%b cnt=%0d expected par=%h valid=%b ovr=%b cnt=%0d",
                             $time, a.par, a.valid, a.ovr, a.cnt, e.par, e.valid, e.ovr, e.cnt);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        bus.Serial_IN = 1'b0;
        bus.Shift_EN  = 1'b0;
        bus.Clear     = 1'b0;
        bus.Out_Ack   = 1'b0;
        model_reset();

        #12;
        check("reset par",   int'(bus.Parallel_OUT), 0);
        check("reset valid", int'(bus.Out_Valid),    0);
        check("reset ovr",   int'(bus.Overrun),      0);
        check("reset cnt",   int'(bus.Bit_Count),    0);
        @(negedge CLK);
        RST_N = 1'b1;

        // back-to-back bits 1,0,1,1
        send_word(4'b1101, 0, 1'b0);
        wait_edge();
        check("t1 par",   int'(bus.Parallel_OUT), 13);
        check("t1 valid", int'(bus.Out_Valid),    1);
        check("t1 cnt",   int'(bus.Bit_Count),    0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);

        // same word with 3-cycle gaps
        send_word(4'b1101, 3, 1'b0);
        wait_edge();
        check("t2 par", int'(bus.Parallel_OUT), 13);
        drive(1'b0, 1'b0, 1'b0, 1'b1);

        // overrun: A left unacked, 5 overwrites it
        send_word(4'hA, 0, 1'b0);
        idle();
        send_word(4'h5, 0, 1'b0);
        wait_edge();
        check("t3 par", int'(bus.Parallel_OUT), 5);
        check("t3 ovr", int'(bus.Overrun),      1);
        idle();
        idle();
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        wait_edge();
        check("t3 clr ovr",   int'(bus.Overrun),      0);
        check("t3 clr valid", int'(bus.Out_Valid),    0);
        check("t3 clr par",   int'(bus.Parallel_OUT), 5);

        // ack on the completion edge of 3 over unacked C
        send_word(4'hC, 0, 1'b0);
        idle();
        send_word(4'h3, 0, 1'b1);
        wait_edge();
        check("t4 par",   int'(bus.Parallel_OUT), 3);
        check("t4 valid", int'(bus.Out_Valid),    1);
        check("t4 ovr",   int'(bus.Overrun),      0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);

        // async reset mid-word
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        wait_edge();
        #1;
        RST_N = 1'b0;
        #1;
        check("t5 rst par",   int'(bus.Parallel_OUT), 0);
        check("t5 rst valid", int'(bus.Out_Valid),    0);
        check("t5 rst cnt",   int'(bus.Bit_Count),    0);
        #1;
        RST_N = 1'b1;
        model_reset();
        send_word(4'b0110, 0, 1'b0);
        wait_edge();
        check("t5 par", int'(bus.Parallel_OUT), 6);
        drive(1'b0, 1'b0, 1'b0, 1'b1);

        // Clear wins over Shift_EN after 3 bits
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        wait_edge();
        check("t6 cnt",   int'(bus.Bit_Count), 0);
        check("t6 valid", int'(bus.Out_Valid), 0);
        send_word(4'h9, 1, 1'b0);
        wait_edge();
        check("t6 next par", int'(bus.Parallel_OUT), 9);

        repeat (600) begin
            drive(1'($urandom_range(0, 1)),
                  ($urandom % 10) < 7,
                  ($urandom % 60) == 0,
                  ($urandom % 10) < 3);
        end
        idle();
        repeat (2) @(posedge CLK);
        #2;
        check("scoreboard drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
